// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing constants, pixel/address types and arbiter state enum
package vga_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int H_TOTAL    = 800;
    localparam int V_TOTAL    = 525;
    localparam int PIX_W      = 8;
    localparam int ADDR_W     = 19;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    typedef logic [PIX_W-1:0]  pixel_t;
    typedef logic [ADDR_W-1:0] fb_addr_t;

    typedef enum logic {
        S_SCAN,
        S_DRAIN
    } arb_state_t;

    typedef struct packed {
        fb_addr_t addr;
        pixel_t   data;
    } wr_entry_t;

    // Sy*640 + Sx built from shifts so no multiplier is needed.
    function automatic fb_addr_t scan_addr(input logic [9:0] sy, input logic [9:0] sx);
        return fb_addr_t'({sy, 9'd0}) + fb_addr_t'({sy, 7'd0}) + fb_addr_t'(sx);
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// rtl/vga_fb_arbiter_if.sv - drawing-engine write request handshake
interface vga_fb_arbiter_if;

    logic               wr_valid;
    logic               wr_ready;
    vga_pkg::fb_addr_t  wr_addr;
    vga_pkg::pixel_t    wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/vga_wr_fifo.sv
// rtl/vga_wr_fifo.sv - small synchronous write-request buffer with registered ready
module vga_wr_fifo
    import vga_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  wr_entry_t        i_push_data,
    input  logic             i_pop,
    output wr_entry_t        o_pop_data,
    output logic             o_ready,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    wr_entry_t        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             ready_q;

    always_comb begin
        level_d = level_q;
        case ({i_push, i_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

    // Ready is registered so it reads 0 while reset is held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (i_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (i_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            ready_q <= (level_d != LVL_W'(FIFO_DEPTH));
        end
    end

    assign o_pop_data = mem_q[rd_ptr_q];
    assign o_ready    = ready_q;
    assign o_empty    = (level_q == '0);
    assign o_level    = level_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - framebuffer RAM arbiter, scanout first; VGA_FB_VBLANK_ONLY_EN restricts drains to vblank
module vga_fb_arbiter
    import vga_pkg::*;
(
    input  logic             i_VGA_CLOCK,
    input  logic             i_rst,
    input  logic             i_de,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic [9:0]       i_Sx,
    input  logic [9:0]       i_Sy,
    vga_fb_arbiter_if.slave  wr,
    output fb_addr_t         o_mem_addr,
    output logic             o_mem_we,
    output pixel_t           o_mem_wdata,
    input  pixel_t           i_mem_rdata,
    output pixel_t           o_pixel,
    output logic             o_de,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic [LVL_W-1:0] o_fifo_level
);

    arb_state_t state_q;
    fb_addr_t   mem_addr_q;
    logic       mem_we_q;
    pixel_t     mem_wdata_q;
    pixel_t     pixel_q;
    logic [1:0] de_q;
    logic [1:0] hs_q;
    logic [1:0] vs_q;

    wr_entry_t  head;
    logic       fifo_ready;
    logic       fifo_empty;
    logic       push;
    logic       drain_ok;

    assign push        = wr.wr_valid && fifo_ready;
    assign wr.wr_ready = fifo_ready;

`ifdef VGA_FB_VBLANK_ONLY_EN
    assign drain_ok = !i_de && !fifo_empty && (state_q == S_DRAIN) && (i_Sy >= 10'(V_ACTIVE));
`else
    assign drain_ok = !i_de && !fifo_empty && (state_q == S_DRAIN);
`endif

    vga_wr_fifo u_fifo (
        .i_clk       (i_VGA_CLOCK),
        .i_rst       (i_rst),
        .i_push      (push),
        .i_push_data ('{addr: wr.wr_addr, data: wr.wr_data}),
        .i_pop       (drain_ok),
        .o_pop_data  (head),
        .o_ready     (fifo_ready),
        .o_empty     (fifo_empty),
        .o_level     (o_fifo_level)
    );

    // State follows last cycle's de, so the first blank cycle never writes.
    always_ff @(posedge i_VGA_CLOCK) begin
        if (i_rst) begin
            state_q     <= S_SCAN;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            pixel_q     <= '0;
            de_q        <= '0;
            hs_q        <= '0;
            vs_q        <= '0;
        end else begin
            state_q  <= i_de ? S_SCAN : S_DRAIN;
            mem_we_q <= 1'b0;
            if (i_de) begin
                mem_addr_q <= scan_addr(i_Sy, i_Sx);
            end else if (drain_ok) begin
                mem_addr_q  <= head.addr;
                mem_wdata_q <= head.data;
                mem_we_q    <= 1'b1;
            end
            de_q    <= {de_q[0], i_de};
            hs_q    <= {hs_q[0], i_hsync};
            vs_q    <= {vs_q[0], i_vsync};
            pixel_q <= de_q[0] ? i_mem_rdata : '0;
        end
    end

    assign o_mem_addr  = mem_addr_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_pixel     = pixel_q;
    assign o_de        = de_q[1];
    assign o_hsync     = hs_q[1];
    assign o_vsync     = vs_q[1];

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed scoreboard bench for the framebuffer arbiter
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       de = 1'b0, hs = 1'b0, vs = 1'b0;
    logic [9:0] sx = '0, sy = '0;

    vga_fb_arbiter_if wr_if ();

    fb_addr_t         mem_addr;
    logic             mem_we;
    pixel_t           mem_wdata, mem_rdata, pixel;
    logic             o_de, o_hs, o_vs;
    logic [LVL_W-1:0] level;

    function automatic pixel_t pat(input fb_addr_t a);
        if (a == 19'd1285) return 8'hA5;
        return a[7:0] ^ 8'h3C;
    endfunction

    assign mem_rdata = pat(mem_addr);

    vga_fb_arbiter dut (
        .i_VGA_CLOCK  (clk),
        .i_rst        (rst),
        .i_de         (de),
        .i_hsync      (hs),
        .i_vsync      (vs),
        .i_Sx         (sx),
        .i_Sy         (sy),
        .wr           (wr_if),
        .o_mem_addr   (mem_addr),
        .o_mem_we     (mem_we),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_pixel      (pixel),
        .o_de         (o_de),
        .o_hsync      (o_hs),
        .o_vsync      (o_vs),
        .o_fifo_level (level)
    );

    typedef struct {
        logic   de;
        logic   hs;
        logic   vs;
        pixel_t pix;
    } vid_t;

    vid_t      vq[$];
    wr_entry_t wq[$];
    int        total = 0;
    int        bad = 0;
    logic      de_prev = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic      acc, exp_we, de_in;
        wr_entry_t e, h;
        vid_t      v;
        fb_addr_t  exp_addr;
        acc    = wr_if.wr_valid && wr_if.wr_ready;
        exp_we = !de && !de_prev && (wq.size() > 0);
`ifdef VGA_FB_VBLANK_ONLY_EN
        exp_we = exp_we && (sy >= 10'd480);
`endif
        exp_addr = fb_addr_t'(sy * 640 + sx);
        v.de  = de;
        v.hs  = hs;
        v.vs  = vs;
        v.pix = de ? pat(exp_addr) : 8'h00;
        vq.push_back(v);
        de_in  = de;
        e.addr = wr_if.wr_addr;
        e.data = wr_if.wr_data;
        @(posedge clk);
        #1;
        de_prev = de_in;
        chk("mem_we", mem_we, exp_we);
        if (exp_we && wq.size() > 0) begin
            h = wq.pop_front();
            chk("wr_addr", mem_addr, h.addr);
            chk("wr_data", mem_wdata, h.data);
        end
        if (de_in) chk("scan_addr", mem_addr, exp_addr);
        if (acc) wq.push_back(e);
        chk("level", level, wq.size());
        chk("ready", wr_if.wr_ready, (wq.size() != FIFO_DEPTH));
        if (vq.size() == 2) begin
            v = vq.pop_front();
            chk("o_de", o_de, v.de);
            chk("o_hsync", o_hs, v.hs);
            chk("o_vsync", o_vs, v.vs);
            chk("o_pixel", pixel, v.pix);
        end
    endtask

    task automatic run(input int n, input logic d, input int x0, input int y);
        for (int i = 0; i < n; i++) begin
            de = d;
            sx = 10'(x0 + i);
            sy = 10'(y);
            step();
        end
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_addr", mem_addr, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_pixel", pixel, 0);
        chk("rst_de", o_de, 0);
        chk("rst_hsync", o_hs, 0);
        chk("rst_vsync", o_vs, 0);
        chk("rst_ready", wr_if.wr_ready, 0);
        chk("rst_level", level, 0);
        vq.delete();
        wq.delete();
        de_prev = 1'b1;
    endtask

    task automatic wr_set(input logic valid, input fb_addr_t a, input pixel_t d);
        wr_if.wr_valid = valid;
        wr_if.wr_addr  = a;
        wr_if.wr_data  = d;
    endtask

    initial begin
        wr_set(1'b1, 19'h00123, 8'h77);
        for (int i = 0; i < 3; i++) reset_cycle();
        rst = 1'b0;
        wr_set(1'b0, '0, '0);
        run(1, 1'b0, 700, 1);

        // single active pixel, RAM returns 0xA5 for address 1285
        run(4, 1'b1, 5, 2);

        // fill the buffer during an active line
        for (int i = 0; i < 6; i++) begin
            wr_set(1'b1, fb_addr_t'(10 + i), pixel_t'(8'h11 + i));
            run(1, 1'b1, 20 + i, 2);
        end
        wr_set(1'b0, '0, '0);
        chk("full_level", level, 4);
        run(2, 1'b1, 26, 2);

        // horizontal blank drain
        hs = 1'b1;
        run(6, 1'b0, 640, 2);
        hs = 1'b0;
        run(2, 1'b0, 646, 2);

        // vertical blank drains anything left in either build
        vs = 1'b1;
        run(6, 1'b0, 0, 490);
        vs = 1'b0;

        // push and pop in the same blank cycle at level 2
        for (int i = 0; i < 2; i++) begin
            wr_set(1'b1, fb_addr_t'(100 + i), pixel_t'(8'h21 + i));
            run(1, 1'b1, 600 + i, 479);
        end
        wr_set(1'b0, '0, '0);
        run(1, 1'b0, 640, 480);
        chk("pre_pp_level", level, 2);
        wr_set(1'b1, 19'd102, 8'h23);
        run(1, 1'b0, 641, 480);
        wr_set(1'b1, 19'd103, 8'h24);
        run(1, 1'b0, 642, 480);
        wr_set(1'b1, 19'h7FFFF, 8'hEE);
        run(1, 1'b0, 643, 480);
        chk("pushpop_level", level, 2);
        wr_set(1'b0, '0, '0);
        run(4, 1'b0, 644, 480);

        // write queued on a visible line; hblank may or may not drain it
        wr_set(1'b1, 19'd200, 8'h33);
        run(1, 1'b1, 10, 100);
        wr_set(1'b0, '0, '0);
        run(1, 1'b1, 11, 100);
        run(4, 1'b0, 640, 100);
        run(2, 1'b1, 0, 101);
        run(3, 1'b0, 640, 101);
        run(3, 1'b0, 0, 480);

        // reset while a drain is about to happen
        for (int i = 0; i < 2; i++) begin
            wr_set(1'b1, fb_addr_t'(300 + i), pixel_t'(8'h40 + i));
            run(1, 1'b1, 100 + i, 5);
        end
        wr_set(1'b0, '0, '0);
        run(1, 1'b0, 0, 500);
        de = 1'b0;
        reset_cycle();
        rst = 1'b0;
        run(2, 1'b0, 2, 500);

        // buffer still works after the mid-run reset
        wr_set(1'b1, 19'd400, 8'h5A);
        run(1, 1'b0, 4, 500);
        wr_set(1'b0, '0, '0);
        run(3, 1'b0, 5, 500);
        chk("final_level", level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port pixel framebuffer RAM between VGA scanout reads and a drawing-engine write port.
- Sits between core_480 (consumes its de/sync/Sx/Sy) and the RAM.
- Scanout has absolute priority. Writer requests are buffered in a small FIFO and drained only on cycles the scanout does not need the RAM.
- Emits pixel data with de/hsync/vsync re-aligned to it.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- H_TOTAL, 800, pixel clocks per line (Sx range 0..H_TOTAL-1).
- V_TOTAL, 525, lines per frame (Sy range 0..V_TOTAL-1).
- PIX_W, 8, bits per pixel.
- ADDR_W, 19, RAM address width (must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE).
- FIFO_DEPTH, 4, write-buffer entries (power of two, >= 2).

Ports:
- i_VGA_CLOCK  in  1  pixel clock, all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_de  in  1  timing-core display enable.
- i_hsync  in  1  timing-core hsync.
- i_vsync  in  1  timing-core vsync.
- i_Sx  in  10  current column.
- i_Sy  in  10  current line.
- i_wr_valid  in  1  writer request valid.
- o_wr_ready  out  1  FIFO can accept an entry.
- i_wr_addr  in  ADDR_W  pixel address to write.
- i_wr_data  in  PIX_W  pixel value.
- o_mem_addr  out  ADDR_W  RAM address (registered).
- o_mem_we  out  1  RAM write enable (registered).
- o_mem_wdata  out  PIX_W  RAM write data (registered).
- i_mem_rdata  in  PIX_W  RAM read data, valid 1 cycle after the address.
- o_pixel  out  PIX_W  pixel to DAC.
- o_de  out  1  i_de delayed 2 cycles.
- o_hsync  out  1  i_hsync delayed 2 cycles.
- o_vsync  out  1  i_vsync delayed 2 cycles.
- o_fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (while i_rst=1 at an edge): all outputs 0, FIFO empty, FSM in S_SCAN. o_wr_ready is 0 during reset and 1 from the first cycle after reset release.
- Writer handshake:
  - Entry accepted when i_wr_valid && o_wr_ready.
  - o_wr_ready = !fifo_full, independent of i_wr_valid.
  - Accepted data is held unchanged in the FIFO until drained.
- Scanout:
  - Each cycle with i_de=1: o_mem_addr <= i_Sy*H_ACTIVE + i_Sx, o_mem_we <= 0.
  - For H_ACTIVE=640 the address is computed as (Sy<<9)+(Sy<<7)+Sx, zero-extended to ADDR_W.
- Drain eligibility: drain_ok = !i_de && !fifo_empty && (FSM == S_DRAIN).
  - On drain_ok: pop the head entry; o_mem_addr/o_mem_wdata <= entry, o_mem_we <= 1 for exactly that cycle.
  - Otherwise o_mem_we <= 0.
  - At most one write per cycle.
- FSM:
  - S_SCAN: entered when i_de=1. Moves to S_DRAIN on the first cycle i_de=0.
  - S_DRAIN: moves to S_SCAN on i_de=1.
  - The state register is updated from i_de with no lookahead, so a write and a scanout read never share an output cycle.
- Pixel path:
  - o_pixel <= (de delayed by 1) ? i_mem_rdata : 0.
  - Total latency from i_de/i_Sx to o_pixel is 2 cycles. o_de/o_hsync/o_vsync go through a matching 2-stage delay.
- Boundary conditions:
  - Simultaneous push and pop: level unchanged, both happen.
  - Push when full: impossible, because ready=0.
  - Pop when empty: no write is issued.
  - Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH.
  - Sx=799→0 and Sy=524→0 need no special handling; only i_de gates arbitration.
  - Write address >= H_ACTIVE*V_ACTIVE: passed through unchecked.
  - Reset mid-operation: FIFO contents discarded; any in-flight o_mem_we is cleared on the reset edge.

Optional Feature:
- Macro: VGA_FB_VBLANK_ONLY_EN.
  - Defined: drain additionally requires i_Sy >= V_ACTIVE. Horizontal-blank cycles on visible lines issue no writes, which prevents tearing inside a frame.
  - Undefined: any i_de=0 cycle may drain.

Decomposition:
- Shared package vga_pkg:
  - Timing constants H_ACTIVE, V_ACTIVE, H_TOTAL, V_TOTAL.
  - Typedefs pixel_t (logic [PIX_W-1:0]) and fb_addr_t (logic [ADDR_W-1:0]).
  - Enum arb_state_t {S_SCAN, S_DRAIN}.
- One sub-module, vga_wr_fifo: synchronous FIFO with push/pop/full/empty/level, same clock and i_rst.

Test Plan:
- Reset hold 3 cycles with i_wr_valid=1 → all outputs 0; o_wr_ready=1 on the first cycle after release; o_fifo_level=0.
- Active pixel at Sx=5, Sy=2, RAM returns 0xA5 → o_mem_addr=1285 one cycle later; o_pixel=0xA5 and o_de=1 two cycles after the input.
- During an active line, push 4 writes (addr 10..13, data 0x11..0x14) → o_wr_ready drops after the 4th push, o_fifo_level=4, and o_mem_we stays 0 until i_de falls.
- At Sx=640 (first hblank cycle) with 4 entries queued → o_mem_we=1 on 4 consecutive cycles with addresses 10..13 in order, then level 0.
- Push and pop in the same blank cycle with level=2 → level stays 2; data order preserved.
- With VGA_FB_VBLANK_ONLY_EN defined, queue 1 write at Sy=100 → no o_mem_we during any hblank; write occurs on the first cycle with Sy=480, i_de=0.
